slave_mem_responder: RTL



---
 rtl/slave_mem_responder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/slave_mem_responder.sv
// slave_mem_responder: memory-backed slave endpoint for the crossbar's
// slave-side req/ack protocol. It serves single-word reads and writes from an
// internal word array after a programmable number of wait states.
// Optional feature: define SLAVE_MEM_ADDR_CHECK_EN to flag out-of-range
// addresses. Flagged writes are dropped and flagged reads return 32'hDEAD_BEEF.
module slave_mem_responder #(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        cmd_i,
    output logic        ack_o,
    output logic [31:0] rdata_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic                    cmd_q, cmd_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    inRange_q, inRange_d;
    logic [31:0]             rdata_q, rdata_d;

    logic [31:0]             mem [DEPTH];

    logic [DEPTH_LOG2-1:0]   addrIdx;
    logic                    addrInRange;
    logic                    unused_addr;

    assign addrIdx = addr_i[DEPTH_LOG2+1:2];

`ifdef SLAVE_MEM_ADDR_CHECK_EN
    assign addrInRange = ~|addr_i[30:DEPTH_LOG2+2];
    assign unused_addr = ^{addr_i[31], addr_i[1:0]};
`else
    // Upper address bits are ignored, so the array aliases across the space.
    assign addrInRange = 1'b1;
    assign unused_addr = ^{addr_i[31:DEPTH_LOG2+2], addr_i[1:0]};
`endif

    // Next-state logic: request capture, wait countdown, and read data load.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        cmd_d     = cmd_q;
        wdata_d   = wdata_q;
        inRange_d = inRange_q;
        rdata_d   = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    idx_d     = addrIdx;
                    cmd_d     = cmd_i;
                    wdata_d   = wdata_i;
                    inRange_d = addrInRange;
                    cnt_d     = WAIT_LOAD;
                    state_d   = (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Read data is fetched on the edge that enters ACK, so it is stable for
        // the whole ack cycle. The capture values are used so that a
        // zero-wait read that goes straight from IDLE to ACK sees the new index.
        if ((state_d == S_ACK) && (state_q != S_ACK) && !cmd_d) begin
            rdata_d = inRange_d ? mem[idx_d] : 32'hDEAD_BEEF;
        end
    end

    // Control and capture registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            idx_q     <= '0;
            cmd_q     <= 1'b0;
            wdata_q   <= 32'h0;
            inRange_q <= 1'b0;
            rdata_q   <= 32'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            cmd_q     <= cmd_d;
            wdata_q   <= wdata_d;
            inRange_q <= inRange_d;
            rdata_q   <= rdata_d;
        end
    end

    // Array write commits on the edge that ends the ACK cycle. A reset during
    // ACK clears the state first, so that write is dropped. The array is not reset.
    always_ff @(posedge clk_i) begin
        if ((state_q == S_ACK) && cmd_q && inRange_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign ack_o   = (state_q == S_ACK);
    assign rdata_o = rdata_q;

endmodule
